irq_cond: RTL

// - Interrupt-source conditioner upstream of the interrupt controller: drives its IREQ[7:0] inputs.
// - Per channel: 2-flop sync, polarity select, glitch filter, level/edge mode with pulse stretch.
// - Per-channel 8-bit saturating event counters for debug.
// - Configured over APB; sits on the same APB segment and clock as the PIT/interrupt controller.

---
 rtl/irq_cond_pkg.sv | 19 +
 rtl/irq_cond_if.sv | 19 +
 rtl/irq_cond_chan.sv | 89 ++++++++
 rtl/irq_cond.sv | 102 ++++++++++
 4 files changed

// File: rtl/irq_cond_pkg.sv
// irq_cond_pkg: shared constants for the interrupt-source conditioner.
//   Register word addresses, per-channel mode encodings and the event
//   counter width used by both the channel slice and the top level.
package irq_cond_pkg;

  localparam logic [2:0] ADDR_POL    = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_FILT   = 3'd2;
  localparam logic [2:0] ADDR_STAT   = 3'd3;
  localparam logic [2:0] ADDR_CH_SEL = 3'd4;
  localparam logic [2:0] ADDR_EVCNT  = 3'd5;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  localparam int                 EVCNT_W   = 8;
  localparam logic [EVCNT_W-1:0] EVCNT_MAX = '1;

endpackage

// File: rtl/irq_cond_if.sv
// irq_cond_if: APB slave bus bundle for irq_cond.
//   paddr   word address          psel    select
//   penable access phase          pwrite  1 = write
//   pwdata  write data            prdata  read data
//   pready  ready (zero wait states)
interface irq_cond_if;
  logic [2:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  prdata, pready);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output prdata, pready);
endinterface

// File: rtl/irq_cond_chan.sv
// irq_cond_chan: one interrupt channel.
//   Two-flop synchronizer with polarity flip, hysteresis-free glitch filter,
//   level/edge output with pulse stretch, saturating event counter.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   ext        raw asynchronous source
//   pol        1 = active-low source
//   mode       MODE_LEVEL / MODE_EDGE
//   filt       filter threshold
//   clr        clear event counter (read-clear)
//   flt        filtered level
//   ireq       conditioned request
//   evcnt      event counter
module irq_cond_chan
  import irq_cond_pkg::*;
#(
  parameter int FILT_W  = 4,
  parameter int STRETCH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext,
  input  logic               pol,
  input  logic               mode,
  input  logic [FILT_W-1:0]  filt,
  input  logic               clr,
  output logic               flt,
  output logic               ireq,
  output logic [EVCNT_W-1:0] evcnt
);

  localparam int             ST_W    = $clog2(STRETCH + 1);
  localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH);

  logic              s1;
  logic              s2;
  logic [FILT_W-1:0] fcnt;
  logic [ST_W-1:0]   st;
  logic              flip;
  logic              rise;

  // flt toggles on this edge; rise is that toggle going 0 -> 1, so the
  // stretch counter and event counter act on the same edge flt changes.
  assign flip = (s2 != flt) && (fcnt >= filt);
  assign rise = flip && !flt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      flt   <= 1'b0;
      fcnt  <= '0;
      st    <= '0;
      ireq  <= 1'b0;
      evcnt <= '0;
    end else begin
      s1 <= ext ^ pol;
      s2 <= s1;

      if (s2 == flt) begin
        fcnt <= '0;
      end else if (flip) begin
        flt  <= ~flt;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end

      // Level mode holds the stretch counter at zero, so switching back to
      // edge mode never fires on a flt that is already high.
      if (mode == MODE_LEVEL) begin
        st <= '0;
      end else if (rise) begin
        st <= ST_LOAD;
      end else if (st != '0) begin
        st <= st - 1'b1;
      end

      ireq <= (mode == MODE_LEVEL) ? flt : (st != '0);

      if (clr) begin
        evcnt <= {{(EVCNT_W-1){1'b0}}, rise};
      end else if (rise && (evcnt != EVCNT_MAX)) begin
        evcnt <= evcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_cond.sv
// irq_cond: interrupt-source conditioner feeding the interrupt controller.
//   APB register file (POL, MODE, FILT, STAT, CH_SEL, EVCNT) and NUM_CH
//   irq_cond_chan slices.
// Ports:
//   pclk, preset  clock and synchronous active-high reset
//   apb           APB slave (irq_cond_if.slave)
//   ext_irq       raw asynchronous sources
//   ireq          conditioned requests
module irq_cond
  import irq_cond_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int FILT_W  = 4,
  parameter int STRETCH = 4
) (
  input  logic              pclk,
  input  logic              preset,
  irq_cond_if.slave         apb,
  input  logic [NUM_CH-1:0] ext_irq,
  output logic [NUM_CH-1:0] ireq
);

  localparam logic [3:0] NUM_CH_U = 4'(NUM_CH);

  logic [NUM_CH-1:0]  pol;
  logic [NUM_CH-1:0]  mode;
  logic [FILT_W-1:0]  filt;
  logic [2:0]         ch_sel;
  logic [NUM_CH-1:0]  flt;
  logic [NUM_CH-1:0]  clr;
  logic [EVCNT_W-1:0] evcnt [NUM_CH];
  logic               access;
  logic               wr;
  logic               rd;
  logic               sel_valid;
  logic [31:0]        rdata;
  logic               unused_pwdata;

  assign access     = apb.psel & apb.penable;
  assign wr         = access & apb.pwrite;
  assign rd         = access & ~apb.pwrite;
  assign sel_valid  = ({1'b0, ch_sel} < NUM_CH_U);
  assign apb.pready = access;
  assign apb.prdata = rdata;

  assign unused_pwdata = ^apb.pwdata;

  always_ff @(posedge pclk) begin
    if (preset) begin
      pol    <= '0;
      mode   <= '0;
      filt   <= '0;
      ch_sel <= '0;
    end else if (wr) begin
      case (apb.paddr)
        ADDR_POL:    pol    <= apb.pwdata[NUM_CH-1:0];
        ADDR_MODE:   mode   <= apb.pwdata[NUM_CH-1:0];
        ADDR_FILT:   filt   <= apb.pwdata[FILT_W-1:0];
        ADDR_CH_SEL: ch_sel <= apb.pwdata[2:0];
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign clr[i] = rd && (apb.paddr == ADDR_EVCNT) && (ch_sel == 3'(i));

    irq_cond_chan #(
      .FILT_W  (FILT_W),
      .STRETCH (STRETCH)
    ) u_chan (
      .clk   (pclk),
      .rst   (preset),
      .ext   (ext_irq[i]),
      .pol   (pol[i]),
      .mode  (mode[i]),
      .filt  (filt),
      .clr   (clr[i]),
      .flt   (flt[i]),
      .ireq  (ireq[i]),
      .evcnt (evcnt[i])
    );
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (apb.paddr)
        ADDR_POL:    rdata[NUM_CH-1:0] = pol;
        ADDR_MODE:   rdata[NUM_CH-1:0] = mode;
        ADDR_FILT:   rdata[FILT_W-1:0] = filt;
        ADDR_STAT:   rdata[NUM_CH-1:0] = flt;
        ADDR_CH_SEL: rdata[2:0]        = ch_sel;
        ADDR_EVCNT: begin
          if (sel_valid) rdata[EVCNT_W-1:0] = evcnt[ch_sel];
        end
        default: ;
      endcase
    end
  end

endmodule
